fixed_point_square: RTL and testbench
=====================================

// Module: fixed_point_square
// PURPOSE
//  Iterative unsigned fixed-point squarer. Computes y = x*x for a Q(WIDTH-FRACT_BITS).FRACT_BITS operand.
//  Uses a radix-2 shift-add datapath, one multiplier bit per cycle.
//  Result is rounded half-up and saturated back to the operand format.
//  Inverse companion of the fixed-point square-root unit: sqrt outputs are squared to recover variance
//  terms, and the bench uses it to cross-check sqrt results.
// PARAMETERS
//  WIDTH       32  total operand/result width in bits (unsigned)
//  FRACT_BITS  16  fractional bits of operand and result; 0 < FRACT_BITS < WIDTH
// PORTS
//  i_clk       in   1                   clock, all state updates on rising edge
//  i_rst_n     in   1                   synchronous reset, active-low
//  i_start     in   1                   start request; operand sampled on the same edge
//  i_x         in   WIDTH               operand x, unsigned Q format
//  o_busy      out  1                   calculation in progress
//  o_valid     out  1                   one-cycle pulse: result outputs updated
//  o_sq        out  WIDTH               x*x, rounded/saturated, same Q format as i_x
//  o_int       out  WIDTH-FRACT_BITS    integer field of o_sq (o_sq[WIDTH-1:FRACT_BITS])
//  o_frac      out  FRACT_BITS          fractional field of o_sq (o_sq[FRACT_BITS-1:0])
//  o_overflow  out  1                   result saturated; valid alongside o_sq
// BEHAVIOUR
//  Reset (i_rst_n==0 at an edge): state IDLE, counter 0.
//   o_busy=0, o_valid=0, o_sq/o_int/o_frac=0, o_overflow=0.
//   Reset wins over i_start. Reset mid-CALC aborts with no o_valid and clears outputs.
//  FSM states: IDLE, CALC, DONE.
//   IDLE/DONE + i_start=1: latch mcand=i_x, mplier=i_x, acc(2*WIDTH bits)=0, cnt=0; go CALC; o_busy=1.
//   CALC, each edge:
//    - if mplier[0], acc += mcand << cnt
//    - mplier >>= 1, cnt++
//   CALC, edge with cnt==WIDTH-1: final add done; go DONE; o_busy=0; o_valid=1; result registers loaded.
//   DONE: o_valid=1 for exactly this one cycle. Next edge goes IDLE (or CALC if i_start) with o_valid=0.
//   i_start while in CALC: ignored. The operand is not resampled and the running result is unaffected.
//  Latency: start accepted at edge N -> o_valid high in the cycle after edge N+WIDTH
//   (WIDTH cycles, 32 by default). Back-to-back start is allowed in the DONE cycle.
//  Result registers (o_sq, o_int, o_frac, o_overflow) hold until the next result load or reset.
//   They are not cleared by a new start.
//  Arithmetic, with p = full 2*WIDTH-bit product and r = p + 2^(FRACT_BITS-1), using 2*WIDTH+1 bits:
//   - if r >> (FRACT_BITS+WIDTH) != 0: o_sq = all ones, o_overflow = 1
//   - else: o_sq = r[FRACT_BITS+WIDTH-1:FRACT_BITS], o_overflow = 0
//  Counter width: $clog2(WIDTH). x=0 runs the full WIDTH cycles (no early exit).
// TESTING (WIDTH=32, FRACT_BITS=16)
//  1. i_x=0x00030000 (3.0): o_sq=0x00090000, o_int=9, o_frac=0, o_overflow=0.
//     o_valid exactly 32 cycles after start, for 1 cycle.
//  2. i_x=0x00018000 (1.5): o_sq=0x00024000 (2.25).
//     i_x=0x00000100: o_sq=0x00000001.
//  3. Rounding: i_x=0x000000B5 -> o_sq=0 (p=32761 rounds down).
//     i_x=0x000000B6 -> o_sq=1 (p=33124 rounds up).
//  4. Saturation: i_x=0x00FFFFFF -> o_sq=0xFFFFFE00, o_overflow=0.
//     i_x=0x01000000 (256.0) -> o_sq=0xFFFFFFFF, o_overflow=1.
//  5. Start 0x00030000, pulse i_start with 0x00050000 mid-CALC -> single o_valid, o_sq=0x00090000.
//     Start issued in DONE cycle -> next result follows 32 cycles later.
//  6. i_rst_n=0 for one cycle at cycle 10 of CALC -> next cycle o_busy=0, o_valid=0, outputs 0.
//     No o_valid for 40 cycles afterwards.

Source files
------------

// File: rtl/fixed_point_square.sv
// Iterative unsigned fixed-point squarer: radix-2 shift-add, one multiplier bit per cycle,
// result rounded half-up and saturated back to the operand Q format.
module fixed_point_square #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned FRACT_BITS = 16
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic                        i_start,
  input  logic [WIDTH-1:0]            i_x,
  output logic                        o_busy,
  output logic                        o_valid,
  output logic [WIDTH-1:0]            o_sq,
  output logic [WIDTH-FRACT_BITS-1:0] o_int,
  output logic [FRACT_BITS-1:0]       o_frac,
  output logic                        o_overflow
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned RND_W = ACC_W + 1;
  localparam logic [RND_W-1:0] RND_HALF = {{(RND_W-1){1'b0}}, 1'b1} << (FRACT_BITS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [ACC_W-1:0]   acc_q;
  logic [CNT_W-1:0]   cnt_q;

  logic               last_c;
  logic               accept_c;
  logic [ACC_W-1:0]   addend_c;
  logic [ACC_W-1:0]   acc_sum_c;
  logic [RND_W-1:0]   rnd_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   sq_c;

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic; a start is only taken outside CALC
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        accept_c = i_start;
        state_d  = i_start ? S_CALC : S_IDLE;
      end
      S_CALC: begin
        last_c = (cnt_q == CNT_W'(WIDTH - 1));
        if (last_c) state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Shift-add step and round/saturate of the final accumulator value
  always_comb begin
    addend_c  = mplier_q[0] ? (ACC_W'(mcand_q) << cnt_q) : '0;
    acc_sum_c = acc_q + addend_c;
    rnd_c     = RND_W'(acc_sum_c) + RND_HALF;
    ovf_c     = (rnd_c >> (FRACT_BITS + WIDTH)) != '0;
    sq_c      = ovf_c ? '1 : WIDTH'(rnd_c >> FRACT_BITS);
  end

  // Datapath and result registers; results persist across new starts
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      mcand_q    <= '0;
      mplier_q   <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_sq       <= '0;
      o_int      <= '0;
      o_frac     <= '0;
      o_overflow <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (accept_c) begin
        mcand_q  <= i_x;
        mplier_q <= i_x;
        acc_q    <= '0;
        cnt_q    <= '0;
        o_busy   <= 1'b1;
      end else if (state_q == S_CALC) begin
        acc_q    <= acc_sum_c;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNT_W'(1);
        if (last_c) begin
          o_busy     <= 1'b0;
          o_valid    <= 1'b1;
          o_sq       <= sq_c;
          o_int      <= sq_c[WIDTH-1:FRACT_BITS];
          o_frac     <= sq_c[FRACT_BITS-1:0];
          o_overflow <= ovf_c;
        end
      end
    end
  end

endmodule

// File: tb/tb_fixed_point_square.sv
// Bench for fixed_point_square: directed corner cases plus random operands checked
// against a plain-arithmetic reference of the rounded, saturated square.
module tb_fixed_point_square;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_start;
  logic [31:0] i_x;
  logic        o_busy;
  logic        o_valid;
  logic [31:0] o_sq;
  logic [15:0] o_int;
  logic [15:0] o_frac;
  logic        o_overflow;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] hold_sq  = '0;
  logic        hold_ovf = 1'b0;

  fixed_point_square #(.WIDTH(32), .FRACT_BITS(16)) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_x        (i_x),
    .o_busy     (o_busy),
    .o_valid    (o_valid),
    .o_sq       (o_sq),
    .o_int      (o_int),
    .o_frac     (o_frac),
    .o_overflow (o_overflow)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // {overflow, square}: exact product, add half an LSB, saturate if it leaves the format
  function automatic logic [32:0] model(input logic [31:0] x);
    logic [64:0] r;
    r = 65'(x) * 65'(x) + 65'(32768);
    if ((r >> 48) != 65'(0)) return {1'b1, 32'hFFFF_FFFF};
    return {1'b0, r[47:16]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge
  task automatic start_op(input logic [31:0] x);
    i_start = 1'b1;
    i_x     = x;
    @(posedge i_clk);
    @(negedge i_clk);
    i_start = 1'b0;
    i_x     = $urandom;
    check("busy_after_start", 64'(o_busy), 64'(1));
    check("hold_sq_on_start", 64'(o_sq), 64'(hold_sq));
    check("hold_ovf_on_start", 64'(o_overflow), 64'(hold_ovf));
  endtask

  task automatic wait_valid(input int lat0, output int lat);
    lat = lat0;
    while (!o_valid && lat < 45) begin
      @(negedge i_clk);
      lat++;
    end
  endtask

  task automatic check_result(input string tag, input logic [31:0] x, input int lat);
    logic [32:0] m;
    m = model(x);
    check({tag, "_latency"}, 64'(lat), 64'(32));
    check({tag, "_sq"}, 64'(o_sq), 64'(m[31:0]));
    check({tag, "_int"}, 64'(o_int), 64'(m[31:16]));
    check({tag, "_frac"}, 64'(o_frac), 64'(m[15:0]));
    check({tag, "_ovf"}, 64'(o_overflow), 64'(m[32]));
    check({tag, "_busy_done"}, 64'(o_busy), 64'(0));
    hold_sq  = m[31:0];
    hold_ovf = m[32];
  endtask

  task automatic run_op(input string tag, input logic [31:0] x);
    int lat;
    start_op(x);
    wait_valid(0, lat);
    check_result(tag, x, lat);
    @(negedge i_clk);
    check({tag, "_valid_pulse"}, 64'(o_valid), 64'(0));
  endtask

  initial begin
    int lat;
    int nvalid;
    logic [31:0] rx;
    logic [31:0] dir_x [8];

    i_rst_n = 1'b0;
    i_start = 1'b1;  // reset must win over start
    i_x     = 32'h0003_0000;
    repeat (3) @(negedge i_clk);
    check("rst_busy", 64'(o_busy), 64'(0));
    check("rst_valid", 64'(o_valid), 64'(0));
    check("rst_sq", 64'(o_sq), 64'(0));
    check("rst_ovf", 64'(o_overflow), 64'(0));
    i_start = 1'b0;
    i_rst_n = 1'b1;
    @(negedge i_clk);

    dir_x = '{32'h0003_0000, 32'h0001_8000, 32'h0000_0100, 32'h0000_00B5,
              32'h0000_00B6, 32'h00FF_FFFF, 32'h0100_0000, 32'h0000_0000};
    foreach (dir_x[i]) run_op($sformatf("dir%0d", i), dir_x[i]);

    // Spot checks of the documented values, independent of the model
    run_op("three", 32'h0003_0000);
    check("three_abs", 64'(o_sq), 64'h0009_0000);
    run_op("sat", 32'h0100_0000);
    check("sat_abs", 64'({o_overflow, o_sq}), 64'h1_FFFF_FFFF);
    run_op("nearsat", 32'h00FF_FFFF);
    check("nearsat_abs", 64'({o_overflow, o_sq}), 64'h0_FFFF_FE00);

    // Start pulse mid-CALC must be ignored
    start_op(32'h0003_0000);
    repeat (10) @(negedge i_clk);
    i_start = 1'b1;
    i_x     = 32'h0005_0000;
    @(negedge i_clk);
    i_start = 1'b0;
    wait_valid(11, lat);
    check_result("midstart", 32'h0003_0000, lat);
    nvalid = 0;
    repeat (35) begin
      @(negedge i_clk);
      if (o_valid) nvalid++;
    end
    check("midstart_single_valid", 64'(nvalid), 64'(0));

    // Back-to-back: start issued in the DONE cycle
    start_op(32'h0001_8000);
    wait_valid(0, lat);
    check_result("b2b_a", 32'h0001_8000, lat);
    start_op(32'h0000_00B6);
    wait_valid(0, lat);
    check_result("b2b_b", 32'h0000_00B6, lat);
    @(negedge i_clk);

    // Random operands across small, in-range and saturating magnitudes
    for (int i = 0; i < 24; i++) begin
      case (i % 3)
        0:       rx = $urandom_range(0, 32'h0000_FFFF);
        1:       rx = $urandom_range(0, 32'h00FF_FFFF);
        default: rx = $urandom;
      endcase
      run_op($sformatf("rnd%0d", i), rx);
    end

    // Reset mid-CALC aborts and clears outputs
    run_op("pre_rst", 32'h0002_0000);
    start_op(32'h0003_0000);
    repeat (9) @(negedge i_clk);
    i_rst_n = 1'b0;
    @(negedge i_clk);
    i_rst_n = 1'b1;
    check("abort_busy", 64'(o_busy), 64'(0));
    check("abort_valid", 64'(o_valid), 64'(0));
    check("abort_sq", 64'(o_sq), 64'(0));
    check("abort_int", 64'(o_int), 64'(0));
    check("abort_frac", 64'(o_frac), 64'(0));
    check("abort_ovf", 64'(o_overflow), 64'(0));
    hold_sq  = '0;
    hold_ovf = 1'b0;
    nvalid = 0;
    repeat (40) begin
      @(negedge i_clk);
      if (o_valid) nvalid++;
    end
    check("abort_no_valid", 64'(nvalid), 64'(0));
    run_op("post_rst", 32'h0001_8000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
